serial_sub_unit: RTL and testbench

- Bit-serial N-bit subtractor controller built around the team's 1-bit full-subtractor cell (ports a, b, bin, diff, borrow).
- Loads two operands, feeds the cell one bit per clock, LSB first, and carries the cell's borrow into the next bit through a flop.
- Shifts the cell's diff bits into a result register and reports the final borrow with a start/done handshake.
- Sits between the operand source (register file / test driver) and the combinational cell, in place of a WIDTH-wide ripple chain.

---
 rtl/serial_sub_unit.sv | 144 ++++++++++++++
 tb/tb_serial_sub_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_unit.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor step per clock, LSB first.
// Optional zero/ovf result flags are enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_sub_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // The oldest result bit would fall off the bottom anyway, so only WIDTH-1 are stored.
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell
  logic             cell_a, cell_b, cell_bin;
  logic             cell_diff, cell_borrow;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  assign cell_a      = a_sh_q[0];
  assign cell_b      = b_sh_q[0];
  assign cell_bin    = brw_q;
  assign cell_diff   = cell_a ^ cell_b ^ cell_bin;
  assign cell_borrow = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & cell_bin);

  assign res_next = {cell_diff, res_sh_q};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        brw_d    = cell_borrow;
        res_sh_d = res_next[WIDTH-1:1];
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d  = StDone;
          diff_d   = res_next;
          borrow_d = cell_borrow;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d   = (res_next == '0);
          // brw_q is the borrow into the MSB at this point.
          ovf_d    = brw_q ^ cell_borrow;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready  = (state_q == StIdle);
  assign done   = (state_q == StDone);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero   = zero_q;
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_unit.sv
// Scoreboard bench for serial_sub_unit: arithmetic reference model, queue of expected results.
// Flag outputs are checked when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub_unit;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         ready, done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero, ovf;
  logic         held_zero, held_ovf;
`endif

  serial_sub_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .ready  (ready),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero   (zero),
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           done_cyc;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           idle_at = 0;
  int           acc_cnt = 0;
  bit           armed = 1'b0;
  logic [W-1:0] held_diff;
  logic         held_borrow;
  int           checks = 0;
  int           errors = 0;

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tbin, input int dc);
    exp_t   e;
    logic [W:0] full;
    longint sr;
    longint lim;
    full     = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
    sr       = longint'($signed(ta)) - longint'($signed(tb)) - longint'(tbin);
    lim      = longint'(1) <<< (W - 1);
    e.done_cyc = dc;
    e.diff   = full[W-1:0];
    e.borrow = full[W];
    e.zero   = (full[W-1:0] == '0);
    e.ovf    = (sr < -lim) || (sr > lim - 1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model of the handshake: decides acceptance from its own busy window.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      exp_q.delete();
      held_diff   = '0;
      held_borrow = 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      held_zero   = 1'b0;
      held_ovf    = 1'b0;
`endif
      idle_at = cyc + 1;
      armed   = 1'b1;
    end else if (start && cyc >= idle_at) begin
      exp_q.push_back(model(a, b, bin, cyc + W));
      idle_at = cyc + W + 2;
      acc_cnt = acc_cnt + 1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (armed) begin
      bit   exp_done;
      exp_t e;
      exp_done = (exp_q.size() > 0) && (exp_q[0].done_cyc == cyc);
      chk("done", 64'(done), 64'(exp_done));
      if (exp_done) begin
        e = exp_q.pop_front();
        held_diff   = e.diff;
        held_borrow = e.borrow;
`ifdef SERIAL_SUB_FLAGS_EN
        held_zero   = e.zero;
        held_ovf    = e.ovf;
`endif
      end
      chk("diff", 64'(diff), 64'(held_diff));
      chk("borrow", 64'(borrow), 64'(held_borrow));
`ifdef SERIAL_SUB_FLAGS_EN
      chk("zero", 64'(zero), 64'(held_zero));
      chk("ovf", 64'(ovf), 64'(held_ovf));
`endif
      chk("ready", 64'(ready), 64'(cyc >= idle_at - 1));
    end
  end

  // Called at a negedge; holds start until the model accepts, then scrambles the inputs.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    int n0;
    int t;
    n0    = acc_cnt;
    t     = 0;
    a     = ta;
    b     = tb;
    bin   = tbin;
    start = 1'b1;
    while (acc_cnt == n0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (acc_cnt == n0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout at cycle %0d: got no acceptance expected one", cyc);
    end
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout at cycle %0d: got %0d pending expected 0", cyc, exp_q.size());
    end
  endtask

  initial begin
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Directed cases, including both boundary cases and the flag cases
    issue(8'd200, 8'd55, 1'b0);
    wait_idle();
    issue(8'd55, 8'd100, 1'b0);
    issue(8'd0, 8'd0, 1'b1);
    issue(8'h5A, 8'h5A, 1'b0);
    issue(8'h00, 8'hFF, 1'b1);
    issue(8'h80, 8'h01, 1'b0);
    issue(8'h7F, 8'hFF, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_idle();

    // start held high: one op every W+2 cycles; inputs change while the last op runs
    a     = 8'd10;
    b     = 8'd3;
    bin   = 1'b0;
    start = 1'b1;
    repeat (25) @(negedge clk);
    start = 1'b0;
    a     = 8'd77;
    b     = 8'd200;
    bin   = 1'b1;
    wait_idle();

    // Reset in the middle of a RUN
    issue(8'd9, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(8'd9, 8'd4, 1'b0);
    wait_idle();

    // rst and start together
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd2;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic with stray start pulses while busy
    for (int i = 0; i < 80; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
